// File: rtl/control_multi_pkg.sv
// Shared encodings for the LEGv8 control path: FSM states, ALU op classes,
// fault codes, opcode classes and the opcode constants.
package control_multi_pkg;

    localparam int OPC_BITS   = 11;
    localparam int ALUOP_BITS = 5;

    typedef enum logic [3:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_EXEC_R    = 4'd2,
        ST_EXEC_I    = 4'd3,
        ST_ALU_WB    = 4'd4,
        ST_MEM_ADDR  = 4'd5,
        ST_MEM_READ  = 4'd6,
        ST_MEM_WB    = 4'd7,
        ST_MEM_WRITE = 4'd8,
        ST_BRANCH    = 4'd9,
        ST_JUMP      = 4'd10,
        ST_TRAP      = 4'd11
    } state_t;

    localparam logic [ALUOP_BITS-1:0] ALUOP_ADD    = 5'd0;
    localparam logic [ALUOP_BITS-1:0] ALUOP_PASS_B = 5'd1;
    localparam logic [ALUOP_BITS-1:0] ALUOP_FUNCT  = 5'd2;

    localparam logic [1:0] FLT_NONE    = 2'b00;
    localparam logic [1:0] FLT_ILLEGAL = 2'b01;
    localparam logic [1:0] FLT_MEMTO   = 2'b10;

    typedef enum logic [2:0] {
        CLS_R       = 3'd0,
        CLS_I       = 3'd1,
        CLS_LOAD    = 3'd2,
        CLS_STORE   = 3'd3,
        CLS_CB      = 3'd4,
        CLS_B       = 3'd5,
        CLS_ILLEGAL = 3'd6
    } opclass_t;

    localparam logic [OPC_BITS-1:0] OPC_ADD    = 11'b10001011000;
    localparam logic [OPC_BITS-1:0] OPC_SUB    = 11'b11001011000;
    localparam logic [OPC_BITS-1:0] OPC_AND    = 11'b10001010000;
    localparam logic [OPC_BITS-1:0] OPC_ORR    = 11'b10101010000;
    localparam logic [OPC_BITS-1:0] OPC_EOR    = 11'b11001010000;
    localparam logic [OPC_BITS-1:0] OPC_ADDS   = 11'b10101011000;
    localparam logic [OPC_BITS-1:0] OPC_SUBS   = 11'b11101011000;
    localparam logic [OPC_BITS-1:0] OPC_ANDS   = 11'b11101010000;
    localparam logic [OPC_BITS-1:0] OPC_LDUR   = 11'b11111000010;
    localparam logic [OPC_BITS-1:0] OPC_LDURSW = 11'b10111000100;
    localparam logic [OPC_BITS-1:0] OPC_LDURH  = 11'b01111000010;
    localparam logic [OPC_BITS-1:0] OPC_LDURB  = 11'b00111000010;
    localparam logic [OPC_BITS-1:0] OPC_STUR   = 11'b11111000000;
    localparam logic [OPC_BITS-1:0] OPC_STURW  = 11'b10111000000;
    localparam logic [OPC_BITS-1:0] OPC_STURH  = 11'b01111000000;
    localparam logic [OPC_BITS-1:0] OPC_STURB  = 11'b00111000000;
    localparam logic [OPC_BITS-1:0] OPC_CBZ    = 11'b10110100000;
    localparam logic [OPC_BITS-1:0] OPC_CBNZ   = 11'b10110101000;
    localparam logic [OPC_BITS-1:0] OPC_B      = 11'b00010100000;

    function automatic logic isMemState(input state_t s);
        return (s == ST_FETCH) || (s == ST_MEM_READ) || (s == ST_MEM_WRITE);
    endfunction

endpackage

// File: rtl/control_multi_opclass_decode.sv
// Opcode classifier: maps an 11-bit LEGv8 opcode onto its instruction class.
// Purely combinational; wildcard rows cover the shorter I/CB/B opcode fields.
module opclass_decode
    import control_multi_pkg::*;
(
    input  logic [OPC_BITS-1:0] iOPCODE,
    output logic [2:0]          oClass
);

    always_comb begin
        oClass = CLS_ILLEGAL;
        casez (iOPCODE)
            OPC_ADD, OPC_SUB, OPC_AND, OPC_ORR, OPC_EOR,
            OPC_ADDS, OPC_SUBS, OPC_ANDS,
            11'b1101001101?:                       oClass = CLS_R;   // LSL/LSR
            11'b1001000100?, 11'b1011000100?,
            11'b1101000100?, 11'b1111000100?,
            11'b1001001000?, 11'b1011001000?,
            11'b1101001000?, 11'b1111001000?:      oClass = CLS_I;
            OPC_LDUR, OPC_LDURSW, OPC_LDURH, OPC_LDURB: oClass = CLS_LOAD;
            OPC_STUR, OPC_STURW, OPC_STURH, OPC_STURB:  oClass = CLS_STORE;
            11'b1011010????:                       oClass = CLS_CB;
            11'b000101?????:                       oClass = CLS_B;
            default:                               oClass = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/control_multi.sv
// Multicycle LEGv8 control FSM with memory wait handshake, watchdog trap,
// illegal-opcode trap and retired-instruction counter.
module control_multi
    import control_multi_pkg::*;
#(
    parameter int OPC_W       = 11,
    parameter int ALUOP_W     = 5,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic               iCLK,
    input  logic               iRST_N,
    input  logic [OPC_W-1:0]   iOPCODE,
    input  logic               iMemReady,
    output logic               oPCWrite,
    output logic               oPCWriteCond,
    output logic               oBranchNZ,
    output logic               oPCSource,
    output logic               oIorD,
    output logic               oMemRead,
    output logic               oMemWrite,
    output logic               oIRWrite,
    output logic               oReg2Loc,
    output logic               oMemToReg,
    output logic               oRegWrite,
    output logic               oOrigAULA,
    output logic [1:0]         oOrigBULA,
    output logic [ALUOP_W-1:0] oALUop,
    output logic               oInstrDone,
    output logic [CNT_W-1:0]   oRetired,
    output logic               oFault,
    output logic [1:0]         oFaultCode,
    output logic [3:0]         oState
);

    localparam int WD_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_t                state;
    state_t                effState;
    logic [WD_W-1:0]       waitCnt;
    logic [2:0]            opClass;
    logic                  memTimeout;
    logic [ALUOP_BITS-1:0] aluOp;

    opclass_decode u_opclass (
        .iOPCODE (iOPCODE),
        .oClass  (opClass)
    );

    assign memTimeout = (MEM_TIMEOUT != 0) && isMemState(state) && !iMemReady &&
                        (waitCnt == WD_W'(MEM_TIMEOUT));

    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state      <= ST_FETCH;
            waitCnt    <= '0;
            oRetired   <= '0;
            oFault     <= 1'b0;
            oFaultCode <= FLT_NONE;
        end else begin
            if (oInstrDone)
                oRetired <= oRetired + 1'b1;

            // State never changes while a memory state waits, so "clear on
            // state change" reduces to clearing whenever we are not stalled.
            if ((MEM_TIMEOUT != 0) && isMemState(state) && !iMemReady && !memTimeout)
                waitCnt <= waitCnt + 1'b1;
            else
                waitCnt <= '0;

            if (memTimeout) begin
                state      <= ST_TRAP;
                oFault     <= 1'b1;
                oFaultCode <= FLT_MEMTO;
            end else begin
                case (state)
                    ST_FETCH:     if (iMemReady) state <= ST_DECODE;
                    ST_DECODE: begin
                        case (opClass)
                            CLS_R:              state <= ST_EXEC_R;
                            CLS_I:              state <= ST_EXEC_I;
                            CLS_LOAD, CLS_STORE: state <= ST_MEM_ADDR;
                            CLS_CB:             state <= ST_BRANCH;
                            CLS_B:              state <= ST_JUMP;
                            default: begin
                                state      <= ST_TRAP;
                                oFault     <= 1'b1;
                                oFaultCode <= FLT_ILLEGAL;
                            end
                        endcase
                    end
                    ST_EXEC_R, ST_EXEC_I: state <= ST_ALU_WB;
                    ST_MEM_ADDR:  state <= (opClass == CLS_LOAD) ? ST_MEM_READ : ST_MEM_WRITE;
                    ST_MEM_READ:  if (iMemReady) state <= ST_MEM_WB;
                    ST_MEM_WRITE: if (iMemReady) state <= ST_FETCH;
                    ST_ALU_WB, ST_MEM_WB, ST_BRANCH, ST_JUMP: state <= ST_FETCH;
                    default:      state <= ST_TRAP;
                endcase
            end
        end
    end

    // While reset is low the outputs look like an idle FETCH, whatever the
    // state register still holds, so no write can escape in the reset cycle.
    assign effState = iRST_N ? state : ST_FETCH;

    always_comb begin
        oPCWrite     = 1'b0;
        oPCWriteCond = 1'b0;
        oBranchNZ    = 1'b0;
        oPCSource    = 1'b0;
        oIorD        = 1'b0;
        oMemRead     = 1'b0;
        oMemWrite    = 1'b0;
        oIRWrite     = 1'b0;
        oReg2Loc     = 1'b0;
        oMemToReg    = 1'b0;
        oRegWrite    = 1'b0;
        oOrigAULA    = 1'b0;
        oOrigBULA    = 2'b00;
        aluOp        = ALUOP_ADD;
        oInstrDone   = 1'b0;
        case (effState)
            ST_FETCH: begin
                oMemRead  = !memTimeout;
                oOrigAULA = 1'b1;
                oOrigBULA = 2'b01;
                oIRWrite  = iMemReady && iRST_N;
                oPCWrite  = iMemReady && iRST_N;
            end
            ST_DECODE: begin
                oOrigAULA = 1'b1;
                oOrigBULA = 2'b11;
                oReg2Loc  = (opClass == CLS_STORE) || (opClass == CLS_CB);
            end
            ST_EXEC_R: aluOp = ALUOP_FUNCT;
            ST_EXEC_I: begin
                oOrigBULA = 2'b10;
                aluOp     = ALUOP_FUNCT;
            end
            ST_ALU_WB: begin
                oRegWrite  = 1'b1;
                oInstrDone = 1'b1;
            end
            ST_MEM_ADDR: begin
                oOrigBULA = 2'b10;
                oReg2Loc  = (opClass == CLS_STORE);
            end
            ST_MEM_READ: begin
                oIorD    = 1'b1;
                oMemRead = !memTimeout;
            end
            ST_MEM_WB: begin
                oRegWrite  = 1'b1;
                oMemToReg  = 1'b1;
                oInstrDone = 1'b1;
            end
            ST_MEM_WRITE: begin
                oIorD      = 1'b1;
                oMemWrite  = !memTimeout;
                oInstrDone = iMemReady;
            end
            ST_BRANCH: begin
                aluOp        = ALUOP_PASS_B;
                oPCWriteCond = 1'b1;
                oPCSource    = 1'b1;
                oBranchNZ    = iOPCODE[3];
                oInstrDone   = 1'b1;
            end
            ST_JUMP: begin
                oPCWrite   = 1'b1;
                oPCSource  = 1'b1;
                oInstrDone = 1'b1;
            end
            default: ;
        endcase
    end

    assign oALUop = ALUOP_W'(aluOp);
    assign oState = state;

endmodule

// File: tb/tb_control_multi.sv
// Directed bench for control_multi: hand-computed per-cycle expectations for
// ADD, LDUR with waits, STUR, CBNZ, B, illegal trap, mid-write reset, watchdog.
module tb_control_multi;

    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_EXEC_R = 4'd2,
                           S_ALU_WB = 4'd4, S_MEM_ADDR = 4'd5, S_MEM_READ = 4'd6,
                           S_MEM_WB = 4'd7, S_MEM_WRITE = 4'd8, S_BRANCH = 4'd9,
                           S_JUMP = 4'd10, S_TRAP = 4'd11;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [10:0] OP_CBNZ = 11'b10110101000;
    localparam logic [10:0] OP_B    = 11'b00010100000;
    localparam logic [10:0] OP_BAD  = 11'b00000000000;

    logic        clk = 1'b0;
    logic        rstN;
    logic [10:0] opcode;
    logic        memReady;
    logic        pcWrite, pcWriteCond, branchNZ, pcSource, iorD, memRead, memWrite;
    logic        irWrite, reg2Loc, memToReg, regWrite, origA, instrDone, fault;
    logic [1:0]  origB, faultCode;
    logic [4:0]  aluOp;
    logic [31:0] retired;
    logic [3:0]  state;

    int checks = 0;
    int errors = 0;

    control_multi dut (
        .iCLK(clk), .iRST_N(rstN), .iOPCODE(opcode), .iMemReady(memReady),
        .oPCWrite(pcWrite), .oPCWriteCond(pcWriteCond), .oBranchNZ(branchNZ),
        .oPCSource(pcSource), .oIorD(iorD), .oMemRead(memRead), .oMemWrite(memWrite),
        .oIRWrite(irWrite), .oReg2Loc(reg2Loc), .oMemToReg(memToReg),
        .oRegWrite(regWrite), .oOrigAULA(origA), .oOrigBULA(origB), .oALUop(aluOp),
        .oInstrDone(instrDone), .oRetired(retired), .oFault(fault),
        .oFaultCode(faultCode), .oState(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic rdy, input logic [10:0] op);
        rstN     = r;
        memReady = rdy;
        opcode   = op;
        #1;
    endtask

    initial begin
        rstN = 1'b0; memReady = 1'b1; opcode = OP_ADD;
        tick(); tick();
        check("rst_state", 32'(state), 32'(S_FETCH));
        check("rst_retired", retired, 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_fcode", 32'(faultCode), 32'd0);
        check("rst_memread", 32'(memRead), 32'd1);
        check("rst_pcwrite", 32'(pcWrite), 32'd0);
        check("rst_irwrite", 32'(irWrite), 32'd0);

        // ADD: FETCH DECODE EXEC_R ALU_WB
        drive(1'b1, 1'b1, OP_ADD);
        check("add_c1_irwrite", 32'(irWrite), 32'd1);
        check("add_c1_pcwrite", 32'(pcWrite), 32'd1);
        check("add_c1_origb", 32'(origB), 32'd1);
        check("add_c1_origa", 32'(origA), 32'd1);
        tick();
        check("add_c2_state", 32'(state), 32'(S_DECODE));
        check("add_c2_origb", 32'(origB), 32'd3);
        check("add_c2_reg2loc", 32'(reg2Loc), 32'd0);
        tick();
        check("add_c3_state", 32'(state), 32'(S_EXEC_R));
        check("add_c3_aluop", 32'(aluOp), 32'd2);
        check("add_c3_regwrite", 32'(regWrite), 32'd0);
        tick();
        check("add_c4_state", 32'(state), 32'(S_ALU_WB));
        check("add_c4_regwrite", 32'(regWrite), 32'd1);
        check("add_c4_memtoreg", 32'(memToReg), 32'd0);
        check("add_c4_done", 32'(instrDone), 32'd1);
        tick();
        check("add_c5_state", 32'(state), 32'(S_FETCH));
        check("add_retired", retired, 32'd1);

        // LDUR with three wait cycles in MEM_READ: 8 cycles total
        drive(1'b1, 1'b1, OP_LDUR);
        check("ld_c1_done", 32'(instrDone), 32'd0);
        tick();
        tick();
        check("ld_c3_state", 32'(state), 32'(S_MEM_ADDR));
        check("ld_c3_origb", 32'(origB), 32'd2);
        check("ld_c3_aluop", 32'(aluOp), 32'd0);
        drive(1'b1, 1'b0, OP_LDUR);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ld_wait_state", 32'(state), 32'(S_MEM_READ));
            check("ld_wait_iord", 32'(iorD), 32'd1);
            check("ld_wait_regwrite", 32'(regWrite), 32'd0);
        end
        drive(1'b1, 1'b1, OP_LDUR);
        check("ld_c7_memread", 32'(memRead), 32'd1);
        tick();
        check("ld_c8_state", 32'(state), 32'(S_MEM_WB));
        check("ld_c8_memtoreg", 32'(memToReg), 32'd1);
        check("ld_c8_regwrite", 32'(regWrite), 32'd1);
        check("ld_c8_done", 32'(instrDone), 32'd1);
        tick();
        check("ld_retired", retired, 32'd2);

        // STUR
        drive(1'b1, 1'b1, OP_STUR);
        tick();
        check("st_c2_reg2loc", 32'(reg2Loc), 32'd1);
        tick();
        check("st_c3_state", 32'(state), 32'(S_MEM_ADDR));
        check("st_c3_reg2loc", 32'(reg2Loc), 32'd1);
        check("st_c3_memwrite", 32'(memWrite), 32'd0);
        tick();
        check("st_c4_state", 32'(state), 32'(S_MEM_WRITE));
        check("st_c4_memwrite", 32'(memWrite), 32'd1);
        check("st_c4_regwrite", 32'(regWrite), 32'd0);
        check("st_c4_done", 32'(instrDone), 32'd1);
        tick();
        check("st_retired", retired, 32'd3);

        // CBNZ then B
        drive(1'b1, 1'b1, OP_CBNZ);
        tick();
        check("cb_c2_reg2loc", 32'(reg2Loc), 32'd1);
        tick();
        check("cb_c3_state", 32'(state), 32'(S_BRANCH));
        check("cb_c3_pcwcond", 32'(pcWriteCond), 32'd1);
        check("cb_c3_nz", 32'(branchNZ), 32'd1);
        check("cb_c3_pcsrc", 32'(pcSource), 32'd1);
        check("cb_c3_aluop", 32'(aluOp), 32'd1);
        tick();
        drive(1'b1, 1'b1, OP_B);
        tick();
        tick();
        check("b_c3_state", 32'(state), 32'(S_JUMP));
        check("b_c3_pcwrite", 32'(pcWrite), 32'd1);
        check("b_c3_pcsrc", 32'(pcSource), 32'd1);
        check("b_c3_done", 32'(instrDone), 32'd1);
        tick();
        check("b_retired", retired, 32'd5);

        // Illegal opcode
        drive(1'b1, 1'b1, OP_BAD);
        tick();
        check("ill_c2_fcode", 32'(faultCode), 32'd0);
        tick();
        check("ill_c3_state", 32'(state), 32'(S_TRAP));
        check("ill_c3_fault", 32'(fault), 32'd1);
        check("ill_c3_fcode", 32'(faultCode), 32'd1);
        check("ill_c3_memread", 32'(memRead), 32'd0);
        check("ill_c3_pcwrite", 32'(pcWrite), 32'd0);
        tick();
        tick();
        check("ill_hold_state", 32'(state), 32'(S_TRAP));
        check("ill_hold_irwrite", 32'(irWrite), 32'd0);
        check("ill_hold_retired", retired, 32'd5);
        drive(1'b0, 1'b1, OP_BAD);
        tick();
        check("ill_rst_state", 32'(state), 32'(S_FETCH));
        check("ill_rst_fault", 32'(fault), 32'd0);
        check("ill_rst_fcode", 32'(faultCode), 32'd0);

        // Reset during a pending store wait
        drive(1'b1, 1'b1, OP_STUR);
        tick();
        tick();
        drive(1'b1, 1'b0, OP_STUR);
        tick();
        check("rmid_state", 32'(state), 32'(S_MEM_WRITE));
        check("rmid_memwrite", 32'(memWrite), 32'd1);
        check("rmid_done", 32'(instrDone), 32'd0);
        drive(1'b0, 1'b0, OP_STUR);
        check("rmid_rst_memwrite", 32'(memWrite), 32'd0);
        check("rmid_rst_memread", 32'(memRead), 32'd1);
        tick();
        check("rmid_after_state", 32'(state), 32'(S_FETCH));
        check("rmid_after_retired", retired, 32'd0);

        // Watchdog: 15 tolerated waits, trap decided in the 16th FETCH cycle
        drive(1'b1, 1'b0, OP_ADD);
        for (int i = 0; i < 15; i++) begin
            check("wd_wait_state", 32'(state), 32'(S_FETCH));
            check("wd_wait_memread", 32'(memRead), 32'd1);
            check("wd_wait_irwrite", 32'(irWrite), 32'd0);
            tick();
        end
        check("wd_last_state", 32'(state), 32'(S_FETCH));
        check("wd_last_memread", 32'(memRead), 32'd0);
        tick();
        check("wd_trap_state", 32'(state), 32'(S_TRAP));
        check("wd_trap_fcode", 32'(faultCode), 32'd2);
        check("wd_trap_fault", 32'(fault), 32'd1);
        drive(1'b1, 1'b1, OP_BAD);
        tick();
        check("wd_hold_fcode", 32'(faultCode), 32'd2);
        check("wd_hold_irwrite", 32'(irWrite), 32'd0);
        check("wd_hold_retired", retired, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
